mod_n_updown_counter: RTL

Parametrised modulo-N synchronous up/down counter. It is the successor to the fixed decade counter and keeps its P/Q/Load/Enable/MR port set. It adds direction control, selectable wrap or saturate mode, out-of-range load detection and a cascade chain (CI/CO), so that multi-digit counters can be built from identical instances. It sits behind the counter interface bundle and is driven by the test module in the same way as the decade counter.

---
 rtl/mod_n_updown_counter.sv | 82 ++++++++
 1 files changed

// File: rtl/mod_n_updown_counter.sv
// Modulo-N synchronous up/down counter with wrap or saturate mode,
// out-of-range load detection and a CI/CO cascade chain for multi-digit counters.
module mod_n_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int SATURATE = 0
) (
  input  logic             CLK,
  input  logic             MR,
  input  logic             Enable,
  input  logic             CI,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] P,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             CO,
  output logic             LoadErr
);

  localparam logic [WIDTH-1:0] LP_MAX  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] LP_ZERO = '0;
  localparam bit               LP_SAT  = (SATURATE != 0);

  if (MODULUS < 2) begin : g_bad_modulus
    $error("mod_n_updown_counter: MODULUS must be at least 2");
  end
  if ((64'd1 << WIDTH) < 64'(MODULUS)) begin : g_bad_width
    $error("mod_n_updown_counter: WIDTH too narrow for MODULUS");
  end

  logic [WIDTH-1:0] r_q;
  logic             r_load_err;
  logic             w_tc;
  logic             w_count;
  logic             w_p_oor;
  logic [WIDTH-1:0] w_q_next;

  // Next count value; terminal handling depends on wrap/saturate mode.
  function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] q,
                                               input logic             up);
    logic [WIDTH-1:0] nxt;
    if (up) begin
      if (q == LP_MAX) nxt = LP_SAT ? q : LP_ZERO;
      else             nxt = q + 1'b1;
    end else begin
      if (q == LP_ZERO) nxt = LP_SAT ? q : LP_MAX;
      else              nxt = q - 1'b1;
    end
    return nxt;
  endfunction

  // Out-of-range loads clamp to the top of the count range.
  function automatic logic [WIDTH-1:0] f_load_val(input logic [WIDTH-1:0] p);
    return (p > LP_MAX) ? LP_MAX : p;
  endfunction

  assign w_p_oor  = (P > LP_MAX);
  assign w_count  = Enable & CI & ~Load & ~MR;
  assign w_q_next = f_step(r_q, Up);

  always_ff @(posedge CLK) begin
    if (MR) begin
      r_q        <= '0;
      r_load_err <= 1'b0;
    end else if (Load) begin
      r_q        <= f_load_val(P);
      r_load_err <= w_p_oor;
    end else begin
      r_load_err <= 1'b0;
      if (w_count) r_q <= w_q_next;
    end
  end

  // Terminal count and carry are combinational so a cascade steps on the wrap edge.
  assign w_tc    = Up ? (r_q == LP_MAX) : (r_q == LP_ZERO);
  assign Q       = r_q;
  assign TC      = w_tc;
  assign CO      = w_tc & Enable & CI;
  assign LoadErr = r_load_err;

endmodule
